seq_detect_sched: RTL and testbench
===================================

Name: seq_detect_sched

Overview:
- Time-multiplexes one serial pattern-detection engine across NUM_CH independent bit-stream requesters.
- Per-channel detection context (bit history plus fill count) is held in the block. A round-robin arbiter grants one channel per cycle.
- Each granted bit updates that channel's history. A registered match pulse reports the channel that completed PATTERN.
- Sits between the stream sources and downstream match logging, replacing one detector FSM per channel.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- PAT_W, 4, pattern length in bits (2..8).
- PATTERN, 4'b1011, target sequence. MSB is the first bit received.
- CNT_W, 8, width of per-channel saturating match counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_CH  per-channel request; channel has a bit to offer.
- bit_in  input  NUM_CH  per-channel data bit, valid when req[i]=1.
- clr_ch  input  NUM_CH  per-channel context clear (synchronous).
- gnt  output  NUM_CH  one-hot combinational grant. bit_in[i] is consumed when req[i]&gnt[i].
- match_valid  output  1  registered one-cycle pulse; the previous cycle's consumed bit completed PATTERN.
- match_ch  output  $clog2(NUM_CH)  channel index for match_valid. Holds its last value otherwise.
- cnt_sel  input  $clog2(NUM_CH)  counter read select.
- cnt_out  output  CNT_W  match count of channel cnt_sel (combinational read).

Behaviour:
- Reset (async, active-high): all histories 0, all fill counts 0, rr pointer 0, match_valid 0, match_ch 0, counters 0. gnt reflects req combinationally even during reset, but nothing is consumed while reset=1.
- Arbitration:
  - Eligible set is req & ~clr_ch.
  - gnt is the first eligible channel at or after rr_ptr, searching with wrap-around. gnt is all-zero if no channel is eligible.
  - At most one grant bit is set.
  - On each consume, rr_ptr <= granted index + 1, modulo NUM_CH. rr_ptr is unchanged when nothing is granted.
- Context update on consume by channel g:
  - hist[g] <= {hist[g][PAT_W-2:0], bit_in[g]}.
  - fill[g] <= min(fill[g]+1, PAT_W).
- Match: hit = (fill[g] >= PAT_W-1) && ({hist[g][PAT_W-2:0], bit_in[g]} == PATTERN).
  - Next cycle: match_valid=1 and match_ch=g. Latency is 1 cycle from the consume edge.
  - Detection is fully overlapping; history is not cleared on a match. With 1011, the stream 1011011 gives 2 matches.
- Fill gating: no match until PAT_W bits have been received since reset or clear. This prevents a false match on the zero-initialised history for patterns with leading zeros.
- clr_ch[i]:
  - Next edge: hist[i]=0 and fill[i]=0. The counter is NOT cleared.
  - A channel being cleared is never granted that cycle, so its bit is not consumed and req must be held.
  - Clearing one channel does not disturb the grants or contexts of the others.
- Non-granted requesters are stalled. Sources hold bit_in[i] until gnt[i].
- Starvation bound: a continuously requesting channel is granted within NUM_CH cycles.
- Reset asserted mid-stream: all contexts are lost immediately, and no match_valid is produced for the in-flight bit.

Optional Feature:
- SEQ_SCHED_CNT_EN defined:
  - Per-channel CNT_W counter increments on the edge where match_valid is set for that channel.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - cnt_out = count[cnt_sel].
- SEQ_SCHED_CNT_EN undefined: no counter flops, and cnt_out is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Single channel 0, req held, bits 1,0,1,1 -> gnt=0001 every cycle. match_valid=1 and match_ch=0 one cycle after the 4th bit. cnt_out(sel 0)=1 with CNT_EN.
- Channel 1 overlap: stream 1,0,1,1,0,1,1 -> exactly 2 match pulses, after bits 4 and 7. cnt_out(sel 1)=2.
- All four req held from reset -> grants 0001, 0010, 0100, 1000, 0001. Each channel is fed 1011 interleaved, giving 4 matches whose match_ch is 0, 1, 2, 3 in order.
- Channel 2 receives 1,0,1, then clr_ch[2] pulses with req[2] high, then 1 -> no grant to channel 2 during the clr cycle and no match after the final 1. A fresh 1,0,1,1 then matches.
- PATTERN=4'b0000, channel 3 fed 0,0,0 after reset -> no match (fill gating). The 4th 0 gives a match.
- Async reset asserted mid-cycle after bits 1,0,1 on channel 0 -> match_valid=0 and counters 0 immediately. Feeding 1 after release gives no match.
- CNT_W=2 with 5 matches on channel 0 -> cnt_out saturates at 3. With the macro undefined, cnt_out=0 throughout.

Source files
------------

// File: rtl/seq_detect_sched.sv
// Round-robin time-multiplexed serial pattern detector shared by NUM_CH bit streams.
// Define SEQ_SCHED_CNT_EN to add per-channel saturating match counters; otherwise cnt_out is 0.
module seq_detect_sched #(
    parameter int               NUM_CH  = 4,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         bit_in,
    input  logic [NUM_CH-1:0]         clr_ch,
    output logic [NUM_CH-1:0]         gnt,
    output logic                      match_valid,
    output logic [$clog2(NUM_CH)-1:0] match_ch,
    input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]          cnt_out
);

    localparam int                IDX_W    = $clog2(NUM_CH);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    logic [PAT_W-1:0]  r_hist [NUM_CH];
    logic [FILL_W-1:0] r_fill [NUM_CH];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_match_valid;
    logic [IDX_W-1:0]  r_match_ch;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_found;
    logic [IDX_W:0]    w_scan;
    logic [PAT_W-1:0]  w_shift;
    logic              w_hit;

    // A channel being cleared must not consume a bit in the same cycle.
    assign w_elig = req & ~clr_ch;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        w_gnt     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NUM_CH)) begin
                w_scan = w_scan - (IDX_W+1)'(NUM_CH);
            end
            if (!w_found && w_elig[w_scan[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[IDX_W-1:0];
            end
        end
        if (w_found) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt     = w_gnt;
    assign w_shift = {r_hist[w_gnt_idx][PAT_W-2:0], bit_in[w_gnt_idx]};
    // Fill gating stops the zeroed history from matching patterns with leading zeros.
    assign w_hit   = w_found && (r_fill[w_gnt_idx] >= FILL_HIT) && (w_shift == PATTERN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_hist[i] <= '0;
                r_fill[i] <= '0;
            end
            r_rr_ptr      <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_ch[i]) begin
                    r_hist[i] <= '0;
                    r_fill[i] <= '0;
                end else if (w_found && (w_gnt_idx == IDX_W'(i))) begin
                    r_hist[i] <= w_shift;
                    if (r_fill[i] < FILL_MAX) begin
                        r_fill[i] <= r_fill[i] + FILL_W'(1);
                    end
                end
            end
            if (w_found) begin
                r_rr_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + IDX_W'(1);
            end
            r_match_valid <= w_hit;
            if (w_hit) begin
                r_match_ch <= w_gnt_idx;
            end
        end
    end

    assign match_valid = r_match_valid;
    assign match_ch    = r_match_ch;

`ifdef SEQ_SCHED_CNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_CH];

    // Counter steps on the same edge that raises match_valid, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_hit && (r_cnt[w_gnt_idx] != '1)) begin
            r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + CNT_W'(1);
        end
    end

    assign cnt_out = r_cnt[cnt_sel];
`else
    logic w_unused_sel;
    assign w_unused_sel = ^cnt_sel;
    assign cnt_out      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scenario bench for seq_detect_sched: default 1011 detector plus a 0000/CNT_W=2 instance.
module tb_seq_detect_sched;

`ifdef SEQ_SCHED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] req, bit_in, clr_ch, gnt;
    logic       match_valid;
    logic [1:0] match_ch, cnt_sel;
    logic [7:0] cnt_out;

    logic       reset_z;
    logic [3:0] req_z, bit_z, clr_z, gnt_z;
    logic       match_valid_z;
    logic [1:0] match_ch_z, cnt_sel_z;
    logic [1:0] cnt_out_z;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    seq_detect_sched u_dut (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr_ch(clr_ch),
        .gnt(gnt), .match_valid(match_valid), .match_ch(match_ch),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    seq_detect_sched #(.NUM_CH(4), .PAT_W(4), .PATTERN(4'b0000), .CNT_W(2)) u_pz (
        .clk(clk), .reset(reset_z), .req(req_z), .bit_in(bit_z), .clr_ch(clr_z),
        .gnt(gnt_z), .match_valid(match_valid_z), .match_ch(match_ch_z),
        .cnt_sel(cnt_sel_z), .cnt_out(cnt_out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every match pulse of the main instance pops the expected channel.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: match_ch=%0d seen, no match expected", match_ch);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (match_ch !== e) begin
                    bad++;
                    $display("FAIL sb_match_ch: got %0d expected %0d", match_ch, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 4'b0101;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_gnt_a: got %b expected 0001", gnt); end
        total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL rst_mv: got %b expected 0", match_valid); end
        total++; if (match_ch !== 2'd0) begin bad++; $display("FAIL rst_mch: got %0d expected 0", match_ch); end
        total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d expected 0", cnt_out); end
        req = 4'b1100;
        #1;
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_gnt_b: got %b expected 0100", gnt); end
        tick();
        req = 4'b0000;
        reset = 1'b0;
        reset_z = 1'b0;
    endtask

    task automatic test_single_ch0();
        logic [3:0] s;
        s = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            req = 4'b0001;
            bit_in = {3'b000, s[3-k]};
            if (k == 3) exp_q.push_back(2'd0);
            @(negedge clk);
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: k=%0d got %b expected 0001", k, gnt); end
            total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL single_early: k=%0d got %b expected 0", k, match_valid); end
            tick();
        end
        req = 4'b0000;
        bit_in = 4'b0000;
        @(negedge clk);
        total++; if (match_valid !== 1'b1) begin bad++; $display("FAIL single_mv: got %b expected 1", match_valid); end
        total++; if (match_ch !== 2'd0) begin bad++; $display("FAIL single_mch: got %0d expected 0", match_ch); end
        total++; if (cnt_out !== (CNT_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL single_cnt: got %0d expected %0d", cnt_out, CNT_EN ? 1 : 0); end
        tick();
        @(negedge clk);
        total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_end: got %b expected 0", match_valid); end
        tick();
    endtask

    task automatic test_overlap_ch1();
        logic [6:0] s;
        int pulses;
        s = 7'b1011011;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            req = 4'b0010;
            bit_in = {2'b00, s[6-k], 1'b0};
            if (k == 3 || k == 6) exp_q.push_back(2'd1);
            @(negedge clk);
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL overlap_gnt: k=%0d got %b expected 0010", k, gnt); end
            if (match_valid === 1'b1) pulses++;
            tick();
        end
        req = 4'b0000;
        cnt_sel = 2'd1;
        @(negedge clk);
        if (match_valid === 1'b1) pulses++;
        total++; if (pulses != 2) begin bad++; $display("FAIL overlap_pulses: got %0d expected 2", pulses); end
        total++; if (cnt_out !== (CNT_EN ? 8'd2 : 8'd0)) begin bad++; $display("FAIL overlap_cnt: got %0d expected %0d", cnt_out, CNT_EN ? 2 : 0); end
        tick();
        cnt_sel = 2'd0;
    endtask

    task automatic test_all_four();
        logic [3:0] pat;
        int sent[4];
        int g;
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            req = 4'b1111;
            for (int i = 0; i < 4; i++) bit_in[i] = (sent[i] < 4) ? pat[3-sent[i]] : 1'b0;
            g = c % 4;
            if (sent[g] == 3) exp_q.push_back(2'(g));
            @(negedge clk);
            total++; if (gnt !== (4'b0001 << g)) begin bad++; $display("FAIL rr_gnt: cycle=%0d got %b expected %b", c, gnt, 4'b0001 << g); end
            tick();
            sent[g]++;
        end
        req = 4'b0000;
        tick();
        cnt_sel = 2'd3;
        @(negedge clk);
        total++; if (cnt_out !== (CNT_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL rr_cnt3: got %0d expected %0d", cnt_out, CNT_EN ? 1 : 0); end
        tick();
        cnt_sel = 2'd0;
    endtask

    task automatic test_clear_ch2();
        logic [3:0] s;
        s = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            req = 4'b0100;
            bit_in = {1'b0, s[3-k], 2'b00};
            @(negedge clk);
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL clr_pre_gnt: k=%0d got %b expected 0100", k, gnt); end
            tick();
        end
        req = 4'b0101;
        bit_in = 4'b0100;
        clr_ch = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL clr_gnt: got %b expected 0001", gnt); end
        tick();
        clr_ch = 4'b0000;
        req = 4'b0100;
        bit_in = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL clr_post_gnt: got %b expected 0100", gnt); end
        tick();
        s = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            req = 4'b0100;
            bit_in = {1'b0, s[3-k], 2'b00};
            if (k == 3) exp_q.push_back(2'd2);
            @(negedge clk);
            if (k == 0) begin
                total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL clr_no_match: got %b expected 0", match_valid); end
            end
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL clr_fresh_gnt: k=%0d got %b expected 0100", k, gnt); end
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        logic [3:0] s;
        s = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            req = 4'b0001;
            bit_in = {3'b000, s[3-k]};
            @(negedge clk);
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mrst_gnt: k=%0d got %b expected 0001", k, gnt); end
            tick();
        end
        req = 4'b0001;
        bit_in = 4'b0001;
        #2;
        reset = 1'b1;
        #1;
        total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL mrst_mv_now: got %b expected 0", match_valid); end
        total++; if (cnt_out !== 8'd0) begin bad++; $display("FAIL mrst_cnt_now: got %0d expected 0", cnt_out); end
        tick();
        reset = 1'b0;
        req = 4'b1001;
        bit_in = 4'b1001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mrst_rr_reset: got %b expected 0001", gnt); end
        total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL mrst_inflight: got %b expected 0", match_valid); end
        tick();
        req = 4'b0000;
        @(negedge clk);
        total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL mrst_ctx_lost: got %b expected 0", match_valid); end
        tick();
    endtask

    task automatic test_fill_gating();
        for (int k = 0; k < 4; k++) begin
            req_z = 4'b1000;
            bit_z = 4'b0000;
            @(negedge clk);
            total++; if (gnt_z !== 4'b1000) begin bad++; $display("FAIL fill_gnt: k=%0d got %b expected 1000", k, gnt_z); end
            total++; if (match_valid_z !== 1'b0) begin bad++; $display("FAIL fill_early: k=%0d got %b expected 0", k, match_valid_z); end
            tick();
        end
        req_z = 4'b0000;
        @(negedge clk);
        total++; if (match_valid_z !== 1'b1) begin bad++; $display("FAIL fill_mv: got %b expected 1", match_valid_z); end
        total++; if (match_ch_z !== 2'd3) begin bad++; $display("FAIL fill_mch: got %0d expected 3", match_ch_z); end
        tick();
    endtask

    task automatic test_saturate();
        int m;
        logic [1:0] exp_cnt;
        cnt_sel_z = 2'd0;
        for (int k = 0; k <= 8; k++) begin
            req_z = (k < 8) ? 4'b0001 : 4'b0000;
            bit_z = 4'b0000;
            @(negedge clk);
            m = (k > 3) ? k - 3 : 0;
            exp_cnt = CNT_EN ? ((m > 3) ? 2'd3 : 2'(m)) : 2'd0;
            total++; if (match_valid_z !== (k >= 4)) begin bad++; $display("FAIL sat_mv: k=%0d got %b expected %0d", k, match_valid_z, k >= 4); end
            total++; if (cnt_out_z !== exp_cnt) begin bad++; $display("FAIL sat_cnt: k=%0d got %0d expected %0d", k, cnt_out_z, exp_cnt); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;   reset_z = 1'b1;
        req = '0;       bit_in = '0;  clr_ch = '0;  cnt_sel = '0;
        req_z = '0;     bit_z = '0;   clr_z = '0;   cnt_sel_z = '0;
        test_reset();
        test_single_ch0();
        test_overlap_ch1();
        test_all_four();
        test_clear_ch2();
        test_mid_reset();
        test_fill_gating();
        test_saturate();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_missing: %0d expected matches never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
